// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  localparam logic [1:0] OVR_DECODE = 2'd0;
  localparam logic [1:0] OVR_FWD1   = 2'd1;
  localparam logic [1:0] OVR_FWD2   = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline register taps and hazard control outputs
interface pipeline_hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] IF_ID_RS1;
  logic [REG_W-1:0] IF_ID_RS2;
  logic [REG_W-1:0] ID_EX_RS1;
  logic [REG_W-1:0] ID_EX_RS2;
  logic             ID_EX_A_IS_RS1;
  logic             ID_EX_B_IS_RS2;
  logic [REG_W-1:0] ID_EX_RD;
  logic             ID_EX_MEMREAD2;
  logic [REG_W-1:0] EX_MS_RD;
  logic             EX_MS_REGWRITE;
  logic [REG_W-1:0] MS_WB_RD;
  logic             MS_WB_REGWRITE;
  logic [1:0]       PCSOURCE;

  logic [1:0]       OVERRIDE_A;
  logic [1:0]       OVERRIDE_B;
  logic             PC_WRITE;
  logic             IF_ID_WRITE;
  logic             IF_ID_FLUSH;
  logic             ID_EX_BUBBLE;
  logic [CNT_W-1:0] STALL_COUNT;
  logic [CNT_W-1:0] FLUSH_COUNT;

  modport master (
    output IF_ID_RS1, IF_ID_RS2, ID_EX_RS1, ID_EX_RS2, ID_EX_A_IS_RS1, ID_EX_B_IS_RS2,
           ID_EX_RD, ID_EX_MEMREAD2, EX_MS_RD, EX_MS_REGWRITE, MS_WB_RD, MS_WB_REGWRITE,
           PCSOURCE,
    input  OVERRIDE_A, OVERRIDE_B, PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE,
           STALL_COUNT, FLUSH_COUNT
  );

  modport slave (
    input  IF_ID_RS1, IF_ID_RS2, ID_EX_RS1, ID_EX_RS2, ID_EX_A_IS_RS1, ID_EX_B_IS_RS2,
           ID_EX_RD, ID_EX_MEMREAD2, EX_MS_RD, EX_MS_REGWRITE, MS_WB_RD, MS_WB_REGWRITE,
           PCSOURCE,
    output OVERRIDE_A, OVERRIDE_B, PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE,
           STALL_COUNT, FLUSH_COUNT
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// rtl/pipeline_hazard_ctrl_forward_sel.sv - operand forwarding select for one ALU input
module forward_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic             use_rs,
  input  logic [REG_W-1:0] ex_ms_rd,
  input  logic             ex_ms_regwrite,
  input  logic [REG_W-1:0] ms_wb_rd,
  input  logic             ms_wb_regwrite,
  output logic [1:0]       sel
);

  // Youngest producer wins; x0 is never forwarded since it is hardwired zero.
  always_comb begin
    sel = OVR_DECODE;
    if (use_rs && ex_ms_regwrite && (ex_ms_rd != '0) && (ex_ms_rd == ex_rs)) begin
      sel = OVR_FWD1;
    end else if (use_rs && ms_wb_regwrite && (ms_wb_rd != '0) && (ms_wb_rd == ex_rs)) begin
      sel = OVR_FWD2;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - forwarding, load-use stall and redirect flush sequencing
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  HAZARD_CLOCK,
  input  logic                  HAZARD_RESET,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hz_state_t        state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       ovr_a;
  logic [1:0]       ovr_b;
  logic             lu;
  logic             br;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;

  forward_sel u_fwd_a (
    .ex_rs          (hz.ID_EX_RS1),
    .use_rs         (hz.ID_EX_A_IS_RS1),
    .ex_ms_rd       (hz.EX_MS_RD),
    .ex_ms_regwrite (hz.EX_MS_REGWRITE),
    .ms_wb_rd       (hz.MS_WB_RD),
    .ms_wb_regwrite (hz.MS_WB_REGWRITE),
    .sel            (ovr_a)
  );

  forward_sel u_fwd_b (
    .ex_rs          (hz.ID_EX_RS2),
    .use_rs         (hz.ID_EX_B_IS_RS2),
    .ex_ms_rd       (hz.EX_MS_RD),
    .ex_ms_regwrite (hz.EX_MS_REGWRITE),
    .ms_wb_rd       (hz.MS_WB_RD),
    .ms_wb_regwrite (hz.MS_WB_REGWRITE),
    .sel            (ovr_b)
  );

  assign lu = hz.ID_EX_MEMREAD2 && (hz.ID_EX_RD != '0) &&
              ((hz.ID_EX_RD == hz.IF_ID_RS1) || (hz.ID_EX_RD == hz.IF_ID_RS2));
  assign br = (hz.PCSOURCE != 2'd0);

  // Pipeline enables for the current cycle; reset holds the front end frozen and flushed.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (HAZARD_RESET) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN, STALL: begin
          if (br) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu && (state == RUN)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        default: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state plus saturating event counters; a redirect outranks a load-use stall.
  always_ff @(posedge HAZARD_CLOCK) begin
    if (HAZARD_RESET) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (br) begin
            state <= FLUSH;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
          end else if (lu) begin
            state <= STALL;
            if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
          end
        end
        STALL: begin
          if (br) begin
            state <= FLUSH;
            if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
          end else begin
            state <= RUN;
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign hz.OVERRIDE_A   = HAZARD_RESET ? OVR_DECODE : ovr_a;
  assign hz.OVERRIDE_B   = HAZARD_RESET ? OVR_DECODE : ovr_b;
  assign hz.PC_WRITE     = pc_write;
  assign hz.IF_ID_WRITE  = if_id_write;
  assign hz.IF_ID_FLUSH  = if_id_flush;
  assign hz.ID_EX_BUBBLE = id_ex_bubble;
  assign hz.STALL_COUNT  = stall_cnt;
  assign hz.FLUSH_COUNT  = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for the hazard controller
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w;
    logic       a_is, b_is, ld, we_m, we_w;
    logic [1:0] pcs;
  } stim_t;

  typedef struct {
    int oa, ob, pw, iw, fl, bb, sc, fc, sc2, fc2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz16 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  hz2 ();

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .HAZARD_CLOCK (clk),
    .HAZARD_RESET (rst),
    .hz           (hz16)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_small (
    .HAZARD_CLOCK (clk),
    .HAZARD_RESET (rst),
    .hz           (hz2)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;
    s.rs1_d = '0; s.rs2_d = '0; s.rs1_x = '0; s.rs2_x = '0;
    s.rd_x = '0; s.rd_m = '0; s.rd_w = '0;
    s.a_is = 1'b0; s.b_is = 1'b0; s.ld = 1'b0; s.we_m = 1'b0; s.we_w = 1'b0;
    s.pcs = 2'd0;
    return s;
  endfunction

  function automatic stim_t lu_stim();
    stim_t s = idle();
    s.ld = 1'b1; s.rd_x = 5'd7; s.rs2_d = 5'd7;
    return s;
  endfunction

  function automatic exp_t ex(int oa, int ob, int pw, int iw, int fl, int bb, int sc, int fc);
    exp_t e;
    e.oa = oa; e.ob = ob; e.pw = pw; e.iw = iw; e.fl = fl; e.bb = bb;
    e.sc = sc; e.fc = fc;
    e.sc2 = (sc > 3) ? 3 : sc;
    e.fc2 = (fc > 3) ? 3 : fc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst;
    hz16.IF_ID_RS1 = s.rs1_d;   hz2.IF_ID_RS1 = s.rs1_d;
    hz16.IF_ID_RS2 = s.rs2_d;   hz2.IF_ID_RS2 = s.rs2_d;
    hz16.ID_EX_RS1 = s.rs1_x;   hz2.ID_EX_RS1 = s.rs1_x;
    hz16.ID_EX_RS2 = s.rs2_x;   hz2.ID_EX_RS2 = s.rs2_x;
    hz16.ID_EX_A_IS_RS1 = s.a_is; hz2.ID_EX_A_IS_RS1 = s.a_is;
    hz16.ID_EX_B_IS_RS2 = s.b_is; hz2.ID_EX_B_IS_RS2 = s.b_is;
    hz16.ID_EX_RD = s.rd_x;     hz2.ID_EX_RD = s.rd_x;
    hz16.ID_EX_MEMREAD2 = s.ld; hz2.ID_EX_MEMREAD2 = s.ld;
    hz16.EX_MS_RD = s.rd_m;     hz2.EX_MS_RD = s.rd_m;
    hz16.EX_MS_REGWRITE = s.we_m; hz2.EX_MS_REGWRITE = s.we_m;
    hz16.MS_WB_RD = s.rd_w;     hz2.MS_WB_RD = s.rd_w;
    hz16.MS_WB_REGWRITE = s.we_w; hz2.MS_WB_REGWRITE = s.we_w;
    hz16.PCSOURCE = s.pcs;      hz2.PCSOURCE = s.pcs;
  endtask

  task automatic cyc(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    apply(s);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val("override_a", 32'(hz16.OVERRIDE_A), e.oa);
      check_val("override_b", 32'(hz16.OVERRIDE_B), e.ob);
      check_val("pc_write", 32'(hz16.PC_WRITE), e.pw);
      check_val("if_id_write", 32'(hz16.IF_ID_WRITE), e.iw);
      check_val("if_id_flush", 32'(hz16.IF_ID_FLUSH), e.fl);
      check_val("id_ex_bubble", 32'(hz16.ID_EX_BUBBLE), e.bb);
      check_val("stall_count", 32'(hz16.STALL_COUNT), e.sc);
      check_val("flush_count", 32'(hz16.FLUSH_COUNT), e.fc);
      check_val("stall_count_w2", 32'(hz2.STALL_COUNT), e.sc2);
      check_val("flush_count_w2", 32'(hz2.FLUSH_COUNT), e.fc2);
      check_val("pc_write_w2", 32'(hz2.PC_WRITE), e.pw);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    apply(s);

    // reset cycle with a live forwarding match: overrides must stay at decode
    s = idle(); s.rst = 1'b1; s.rs1_x = 5'd5; s.a_is = 1'b1; s.rd_m = 5'd5; s.we_m = 1'b1;
    cyc(s, ex(0, 0, 0, 0, 1, 1, 0, 0));

    // EX/MEM beats MEM/WB, then MEM/WB alone
    s = idle(); s.rs1_x = 5'd5; s.a_is = 1'b1; s.rd_m = 5'd5; s.we_m = 1'b1;
    s.rd_w = 5'd5; s.we_w = 1'b1;
    cyc(s, ex(1, 0, 1, 1, 0, 0, 0, 0));
    s.we_m = 1'b0;
    cyc(s, ex(2, 0, 1, 1, 0, 0, 0, 0));

    // x0 never forwarded
    s = idle(); s.rs2_x = 5'd0; s.b_is = 1'b1; s.rd_m = 5'd0; s.we_m = 1'b1;
    s.rd_w = 5'd0; s.we_w = 1'b1;
    cyc(s, ex(0, 0, 1, 1, 0, 0, 0, 0));

    // independent A/B selects, then A disabled by its source flag
    s = idle(); s.rs1_x = 5'd3; s.a_is = 1'b1; s.rs2_x = 5'd9; s.b_is = 1'b1;
    s.rd_m = 5'd3; s.we_m = 1'b1; s.rd_w = 5'd9; s.we_w = 1'b1;
    cyc(s, ex(1, 2, 1, 1, 0, 0, 0, 0));
    s.a_is = 1'b0;
    cyc(s, ex(0, 2, 1, 1, 0, 0, 0, 0));

    // load-use: one stall cycle, LU held but not re-evaluated in STALL
    cyc(lu_stim(), ex(0, 0, 0, 0, 0, 1, 0, 0));
    cyc(lu_stim(), ex(0, 0, 1, 1, 0, 0, 1, 0));
    cyc(idle(),    ex(0, 0, 1, 1, 0, 0, 1, 0));

    // redirect: two flush cycles, LU ignored during FLUSH
    s = idle(); s.pcs = 2'd2;
    cyc(s,         ex(0, 0, 1, 1, 1, 1, 1, 0));
    cyc(lu_stim(), ex(0, 0, 1, 1, 1, 1, 1, 1));
    cyc(idle(),    ex(0, 0, 1, 1, 0, 0, 1, 1));

    // redirect and load-use together: flush only
    s = idle(); s.pcs = 2'd1; s.ld = 1'b1; s.rd_x = 5'd4; s.rs1_d = 5'd4;
    cyc(s,      ex(0, 0, 1, 1, 1, 1, 1, 1));
    cyc(idle(), ex(0, 0, 1, 1, 1, 1, 1, 2));
    cyc(idle(), ex(0, 0, 1, 1, 0, 0, 1, 2));

    // redirect arriving during STALL
    cyc(lu_stim(), ex(0, 0, 0, 0, 0, 1, 1, 2));
    s = idle(); s.pcs = 2'd3;
    cyc(s,         ex(0, 0, 1, 1, 1, 1, 2, 2));

    // reset while in FLUSH, then RUN with cleared counters
    s = idle(); s.rst = 1'b1;
    cyc(s,      ex(0, 0, 0, 0, 1, 1, 2, 3));
    cyc(idle(), ex(0, 0, 1, 1, 0, 0, 0, 0));

    // five load-use events: narrow counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      cyc(lu_stim(), ex(0, 0, 0, 0, 0, 1, k, 0));
      cyc(idle(),    ex(0, 0, 1, 1, 0, 0, k + 1, 0));
    end

    // load into x0 is not a hazard
    s = idle(); s.ld = 1'b1; s.rd_x = 5'd0; s.rs1_d = 5'd0;
    cyc(s,      ex(0, 0, 1, 1, 0, 0, 5, 0));
    cyc(idle(), ex(0, 0, 1, 1, 0, 0, 5, 0));

    repeat (2) @(posedge clk);
    check_val("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
